// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: streams host words onto a master/slave scan chain with a
// generated scan clock, returns the chain's previous contents, then strobes the chip load.
module scan_chain_ctrl #(
  parameter int SC_SIZE     = 128,
  parameter int WORD_W      = 8,
  parameter int DIV         = 2,
  parameter int LOAD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              load_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic              scan_clk,
  output logic              scan_data_in,
  input  logic              scan_data_out,
  output logic              scan_load_chip
);

  localparam int NWORDS = SC_SIZE / WORD_W;
  localparam int BW     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int WW     = $clog2(NWORDS + 1);
  localparam int DW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LW     = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(NWORDS - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LOAD,
    S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic              load_en_q, load_en_d;
  logic [WORD_W-1:0] tx_q, tx_d;
  logic [WORD_W-1:0] rx_q, rx_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]     word_cnt_q, word_cnt_d;
  logic [DW-1:0]     div_cnt_q, div_cnt_d;
  logic [LW-1:0]     load_cnt_q, load_cnt_d;
  logic              wr_ready_c;

  // A pending readback word blocks the next fetch so RX is never overwritten.
  assign wr_ready_c = (state_q == S_FETCH) && !rd_valid_q;

  always_comb begin
    state_d    = state_q;
    load_en_d  = load_en_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    done_d     = 1'b0;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    div_cnt_d  = div_cnt_q;
    load_cnt_d = load_cnt_q;

    if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          load_en_d  = load_en;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (wr_valid && wr_ready_c) begin
          tx_d      = wr_data;
          div_cnt_d = '0;
          state_d   = S_SHIFT_LO;
        end
      end
      S_SHIFT_LO: begin
        if (div_cnt_q == DIV_LAST) begin
          // Old chain bit is sampled before the rising scan_clk edge.
          rx_d      = {scan_data_out, rx_q[WORD_W-1:1]};
          div_cnt_d = '0;
          state_d   = S_SHIFT_HI;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_SHIFT_HI: begin
        if (div_cnt_q == DIV_LAST) begin
          tx_d      = tx_q >> 1;
          div_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d  = '0;
            rd_data_d  = rx_q;
            rd_valid_d = 1'b1;
            word_cnt_d = word_cnt_q + 1'b1;
            if (word_cnt_q != WORD_LAST) begin
              state_d = S_FETCH;
            end else if (load_en_q) begin
              load_cnt_d = '0;
              state_d    = S_LOAD;
            end else begin
              state_d = S_FIN;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = S_SHIFT_LO;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_LOAD: begin
        if (load_cnt_q == LOAD_LAST) begin
          state_d = S_FIN;
        end else begin
          load_cnt_d = load_cnt_q + 1'b1;
        end
      end
      S_FIN: begin
        if (!rd_valid_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      load_en_q  <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      div_cnt_q  <= '0;
      load_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      load_en_q  <= load_en_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      div_cnt_q  <= div_cnt_d;
      load_cnt_q <= load_cnt_d;
    end
  end

  assign wr_ready       = wr_ready_c;
  assign rd_data        = rd_data_q;
  assign rd_valid       = rd_valid_q;
  assign done           = done_q;
  assign busy           = (state_q != S_IDLE);
  assign scan_clk       = (state_q == S_SHIFT_HI);
  assign scan_data_in   = ((state_q == S_SHIFT_LO) || (state_q == S_SHIFT_HI)) ? tx_q[0] : 1'b0;
  assign scan_load_chip = (state_q == S_LOAD);

endmodule
